// File: rtl/wave_mem_ctrl.sv
// wave_mem_ctrl -- wavetable playback controller in front of a single-port RAM.
//
// The block is the only user of the RAM. It arbitrates between table loads
// (wr_*) and playback reads requested by the sample-rate strobe (tick).
// A pending read always wins over a load. Each read takes three cycles from
// tick to sample_valid.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   wr_valid/ready    load handshake; wr_addr/wr_data carry the table entry
//   play_en           playback enable; low resets the read pointer
//   tick              one-cycle sample-rate strobe
//   last_addr         final table index (table length = last_addr+1)
//   step              phase increment (only when WAVE_STEP_EN is defined)
//   sample            registered playback sample, qualified by sample_valid
//   wrap              one-cycle strobe when the read pointer wraps
//   overrun           sticky: tick arrived while a read was still pending
//   mem_addr/data/we  RAM request; mem_q is RAM read data (one cycle latency)
//
// Configuration macro: WAVE_STEP_EN adds the step port (inc = step);
// otherwise the pointer advances by 1.

`ifndef DATA_LEN
`define DATA_LEN 16
`endif
`ifndef ROWS_BASE_2
`define ROWS_BASE_2 8
`endif

module wave_mem_ctrl #(
    parameter int DATA_WIDTH = `DATA_LEN,
    parameter int ADDR_WIDTH = `ROWS_BASE_2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  play_en,
    input  logic                  tick,
    input  logic [ADDR_WIDTH-1:0] last_addr,
`ifdef WAVE_STEP_EN
    input  logic [ADDR_WIDTH-1:0] step,
`endif
    output logic [DATA_WIDTH-1:0] sample,
    output logic                  sample_valid,
    output logic                  wrap,
    output logic                  overrun,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_data,
    output logic                  mem_we,
    input  logic [DATA_WIDTH-1:0] mem_q
);

    typedef enum logic {IDLE, RD} state_t;

    state_t                state, state_next;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic                  pend;
    logic                  play_en_q;
    logic                  grant;

    logic [ADDR_WIDTH-1:0] inc;
    logic [ADDR_WIDTH:0]   nxt;
    logic                  nxt_wraps;
    logic [ADDR_WIDTH-1:0] ptr_inc;
    logic [ADDR_WIDTH-1:0] ptr_wrap;

`ifdef WAVE_STEP_EN
    assign inc = step;
`else
    assign inc = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
`endif

    // Wrap decision needs the carry, so compare in ADDR_WIDTH+1 bits.
    assign nxt       = {1'b0, rd_ptr} + {1'b0, inc};
    assign nxt_wraps = nxt > {1'b0, last_addr};
    // The stored pointer is only ADDR_WIDTH bits, so the subtraction of
    // (last_addr+1) can be done modulo 2^ADDR_WIDTH: -(x+1) == ~x.
    assign ptr_inc   = rd_ptr + inc;
    assign ptr_wrap  = ptr_inc + ~last_addr;

    assign mem_data = wr_data;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Next state and RAM request. A pending read takes the RAM; a load is
    // only accepted in IDLE with nothing pending.
    always_comb begin
        state_next = state;
        grant      = 1'b0;
        wr_ready   = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = wr_addr;
        case (state)
            IDLE: begin
                if (pend) begin
                    grant      = 1'b1;
                    mem_addr   = rd_ptr;
                    state_next = RD;
                end else begin
                    wr_ready = ~rst;
                    mem_we   = wr_valid & ~rst;
                end
            end
            RD:      state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Datapath and status
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr       <= '0;
            pend         <= 1'b0;
            play_en_q    <= 1'b0;
            sample       <= '0;
            sample_valid <= 1'b0;
            wrap         <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            play_en_q    <= play_en;
            sample_valid <= (state == RD);
            wrap         <= 1'b0;

            if (state == RD) sample <= mem_q;

            // pend is only ever set while clear, so a second tick while a
            // read is waiting never queues another read.
            if (!play_en)   pend <= 1'b0;
            else if (grant) pend <= 1'b0;
            else if (tick)  pend <= 1'b1;

            if (play_en_q && !play_en)        overrun <= 1'b0;
            else if (tick && pend && play_en) overrun <= 1'b1;

            if (!play_en) begin
                rd_ptr <= '0;
            end else if (grant) begin
                rd_ptr <= nxt_wraps ? ptr_wrap : ptr_inc;
                wrap   <= nxt_wraps;
            end
        end
    end

endmodule

// File: tb/tb_wave_mem_ctrl.sv
// Self-checking bench for wave_mem_ctrl: behavioural RAM, reference table
// and a pointer model built from the playback rules.
module tb_wave_mem_ctrl;

    localparam int DW = 16;
    localparam int AW = 4;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          rst;
    logic          wr_valid;
    logic          wr_ready;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          play_en;
    logic          tick;
    logic [AW-1:0] last_addr;
`ifdef WAVE_STEP_EN
    logic [AW-1:0] step;
`endif
    logic [DW-1:0] sample;
    logic          sample_valid;
    logic          wrap;
    logic          overrun;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_data;
    logic          mem_we;
    logic [DW-1:0] mem_q;

    int n_tests = 0;
    int n_fail  = 0;

    // reference model state
    logic [DW-1:0] ref_tab [DEPTH];
    int            m_ptr;
    int            m_last;
    int            m_inc;

    wave_mem_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst(rst),
        .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_addr(wr_addr), .wr_data(wr_data),
        .play_en(play_en), .tick(tick), .last_addr(last_addr),
`ifdef WAVE_STEP_EN
        .step(step),
`endif
        .sample(sample), .sample_valid(sample_valid),
        .wrap(wrap), .overrun(overrun),
        .mem_addr(mem_addr), .mem_data(mem_data), .mem_we(mem_we),
        .mem_q(mem_q)
    );

    always #5 clk = ~clk;

    // single-port RAM, read-first, one cycle read latency
    logic [DW-1:0] ram [DEPTH];
    always @(posedge clk) begin
        if (mem_we) ram[mem_addr] <= mem_data;
        mem_q <= ram[mem_addr];
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // next read address and whether the issue wraps, from the pointer rule
    function automatic void model_issue(output int a, output logic w);
        int n;
        a = m_ptr;
        n = m_ptr + m_inc;
        w = (n > m_last);
        m_ptr = w ? (n - (m_last + 1)) % DEPTH : n % DEPTH;
    endfunction

    task automatic load(input int a, input logic [DW-1:0] d);
        logic [AW-1:0] aa;
        aa = a[AW-1:0];
        wr_valid = 1'b1; wr_addr = aa; wr_data = d;
        #1;
        n_tests++;
        if (wr_ready !== 1'b1 || mem_we !== 1'b1 || mem_addr !== aa || mem_data !== d) begin
            n_fail++;
            $display("FAIL load[%0d]: ready=%b we=%b addr=%0d data=%0d, want 1 1 %0d %0d",
                     a, wr_ready, mem_we, mem_addr, mem_data, aa, d);
        end
        cyc();
        wr_valid = 1'b0;
        ref_tab[a] = d;
    endtask

    // one isolated tick: checks grant address, wrap, latency and sample
    task automatic play_tick(input string tag);
        int   ea;
        logic ew;
        model_issue(ea, ew);
        tick = 1'b1;
        cyc();                                  // T+1: read grant
        tick = 1'b0;
        n_tests++;
        if (mem_addr !== ea[AW-1:0] || mem_we !== 1'b0 || wr_ready !== 1'b0 || sample_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL %s grant: addr=%0d we=%b ready=%b sv=%b, want %0d 0 0 0",
                     tag, mem_addr, mem_we, wr_ready, sample_valid, ea);
        end
        cyc();                                  // T+2: RD
        n_tests++;
        if (wrap !== ew || sample_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL %s wrap: wrap=%b sv=%b, want %b 0", tag, wrap, sample_valid, ew);
        end
        cyc();                                  // T+3: sample out
        n_tests++;
        if (sample_valid !== 1'b1 || sample !== ref_tab[ea]) begin
            n_fail++;
            $display("FAIL %s sample: sv=%b sample=%0d, want 1 %0d", tag, sample_valid, sample, ref_tab[ea]);
        end
        cyc();                                  // T+4
        n_tests++;
        if (sample_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL %s pulse_len: sv=%b, want 0", tag, sample_valid);
        end
    endtask

    task automatic restart_play();
        play_en = 1'b0;
        cyc();
        play_en = 1'b1;
        m_ptr = 0;
    endtask

    task automatic test_reset();
        rst = 1'b1; wr_valid = 1'b1; wr_addr = '0; wr_data = '0;
        play_en = 1'b0; tick = 1'b0; last_addr = '0;
`ifdef WAVE_STEP_EN
        step = 1;
`endif
        cyc(); cyc();
        n_tests++;
        if (wr_ready !== 1'b0 || mem_we !== 1'b0 || sample !== '0 || sample_valid !== 1'b0 ||
            wrap !== 1'b0 || overrun !== 1'b0) begin
            n_fail++;
            $display("FAIL reset: ready=%b we=%b sample=%0d sv=%b wrap=%b ovr=%b, want all 0",
                     wr_ready, mem_we, sample, sample_valid, wrap, overrun);
        end
        rst = 1'b0; wr_valid = 1'b0;
        cyc();
    endtask

    task automatic test_load();
        for (int i = 0; i < DEPTH; i++) begin
            if (i < 4) load(i, DW'((i + 1) * 10));
            else       load(i, DW'($urandom_range(0, 65535)));
        end
    endtask

    // table 10,20,30,40, tick every 8 cycles
    task automatic test_playback();
        m_last = 3; last_addr = 3; m_inc = 1;
        restart_play();
        for (int k = 0; k < 5; k++) begin
            play_tick($sformatf("play%0d", k));
            repeat (4) cyc();
        end
    endtask

    // load held during a pending read: deferred until the read is done
    task automatic test_back_to_back();
        int            ea;
        logic          ew;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic [DW-1:0] want;
        a = AW'($urandom_range(4, DEPTH - 1));
        d = DW'($urandom_range(0, 65535));
        model_issue(ea, ew);
        want = ref_tab[ea];
        tick = 1'b1;
        cyc();                                  // T+1: grant
        tick = 1'b0;
        wr_valid = 1'b1; wr_addr = a; wr_data = d;
        #1;
        n_tests++;
        if (wr_ready !== 1'b0 || mem_we !== 1'b0 || mem_addr !== ea[AW-1:0]) begin
            n_fail++;
            $display("FAIL b2b grant: ready=%b we=%b addr=%0d, want 0 0 %0d", wr_ready, mem_we, mem_addr, ea);
        end
        cyc();                                  // T+2: RD
        n_tests++;
        if (wr_ready !== 1'b0 || mem_we !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b rd: ready=%b we=%b, want 0 0", wr_ready, mem_we);
        end
        cyc();                                  // T+3: write lands
        n_tests++;
        if (wr_ready !== 1'b1 || mem_we !== 1'b1 || mem_addr !== a || mem_data !== d ||
            sample_valid !== 1'b1 || sample !== want) begin
            n_fail++;
            $display("FAIL b2b write: ready=%b we=%b addr=%0d sv=%b sample=%0d, want 1 1 %0d 1 %0d",
                     wr_ready, mem_we, mem_addr, sample_valid, sample, a, want);
        end
        cyc();
        wr_valid = 1'b0;
        ref_tab[a] = d;
        repeat (2) cyc();
        play_tick("b2b_after");                 // the written entry is not read here, but RAM must hold it
    endtask

    task automatic test_overrun();
        int   ea;
        logic ew;
        int   pulses;
        restart_play();
        model_issue(ea, ew);
        tick = 1'b1;
        cyc();
        cyc();                                  // second tick seen with pend set
        tick = 1'b0;
        n_tests++;
        if (overrun !== 1'b1) begin
            n_fail++;
            $display("FAIL overrun_set: overrun=%b, want 1", overrun);
        end
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            if (sample_valid === 1'b1) pulses++;
            cyc();
        end
        n_tests++;
        if (pulses != 1) begin
            n_fail++;
            $display("FAIL overrun_reads: sample_valid pulses=%0d, want 1", pulses);
        end
        play_tick("overrun_next");
        n_tests++;
        if (overrun !== 1'b1) begin
            n_fail++;
            $display("FAIL overrun_sticky: overrun=%b, want 1", overrun);
        end
        play_en = 1'b0;
        cyc();
        n_tests++;
        if (overrun !== 1'b0) begin
            n_fail++;
            $display("FAIL overrun_clear: overrun=%b, want 0", overrun);
        end
        play_en = 1'b1;
        m_ptr = 0;
        play_tick("overrun_ptr0");
    endtask

    // play_en dropped while in RD: read still completes, pointer resets
    task automatic test_play_stop();
        int   ea;
        logic ew;
        restart_play();
        play_tick("stop_pre");
        model_issue(ea, ew);
        tick = 1'b1;
        cyc();
        tick = 1'b0;
        cyc();                                  // RD
        play_en = 1'b0;
        cyc();
        n_tests++;
        if (sample_valid !== 1'b1 || sample !== ref_tab[ea]) begin
            n_fail++;
            $display("FAIL stop_complete: sv=%b sample=%0d, want 1 %0d", sample_valid, sample, ref_tab[ea]);
        end
        cyc();
        play_en = 1'b1;
        m_ptr = 0;
        play_tick("stop_ptr0");
    endtask

    task automatic test_reset_mid_rd();
        int pulses;
        m_last = 0; last_addr = 0;              // every issue wraps
        restart_play();
        tick = 1'b1;
        cyc();
        tick = 1'b0;
        cyc();                                  // RD, wrap would be high
        wr_valid = 1'b1;
        rst = 1'b1;
        #1;
        n_tests++;
        if (sample_valid !== 1'b0 || wrap !== 1'b0 || overrun !== 1'b0 || sample !== '0 ||
            wr_ready !== 1'b0 || mem_we !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid_rd: sv=%b wrap=%b ovr=%b sample=%0d ready=%b we=%b, want all 0",
                     sample_valid, wrap, overrun, sample, wr_ready, mem_we);
        end
        cyc();
        rst = 1'b0;
        wr_valid = 1'b0;
        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            if (sample_valid === 1'b1) pulses++;
            cyc();
        end
        n_tests++;
        if (pulses != 0) begin
            n_fail++;
            $display("FAIL rst_no_sample: sample_valid pulses=%0d, want 0", pulses);
        end
        m_last = 3; last_addr = 3;
        m_ptr = 0;
        play_tick("rst_ptr0");
    endtask

`ifdef WAVE_STEP_EN
    task automatic test_step();
        for (int i = 0; i < 8; i++) load(i, DW'(100 + i));
        m_last = 7; last_addr = 7;
        m_inc = 3; step = 3;
        restart_play();
        for (int k = 0; k < 7; k++) begin
            play_tick($sformatf("step3_%0d", k));
            repeat (2) cyc();
        end
        m_inc = 0; step = 0;
        play_tick("step0_a");
        play_tick("step0_b");
        m_inc = 1; step = 1;
    endtask
`endif

    task automatic test_random();
        m_inc = 1;
`ifdef WAVE_STEP_EN
        step = 1;
`endif
        restart_play();
        for (int k = 0; k < 60; k++) begin
            case ($urandom_range(0, 3))
                0: load(int'($urandom_range(0, DEPTH - 1)), DW'($urandom_range(0, 65535)));
                1: begin
                    m_last = int'($urandom_range(0, DEPTH - 1));
                    last_addr = AW'(m_last);
                end
                default: play_tick($sformatf("rnd%0d", k));
            endcase
            repeat ($urandom_range(0, 3)) cyc();
        end
    endtask

    initial begin
        m_ptr = 0; m_last = 0; m_inc = 1;
        test_reset();
        test_load();
        test_playback();
        test_back_to_back();
        test_overrun();
        test_play_stop();
        test_reset_mid_rd();
`ifdef WAVE_STEP_EN
        test_step();
`endif
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
